spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Byte-level protocol engine directly downstream of the SPI slave: consumes its received-byte strobe/byte and feeds its transmit-byte load strobe/byte.
- Decodes each chip-select frame as a command byte plus data bytes, and turns it into register-bus writes and reads in the i_Clk domain.
- Read data is returned on MISO one byte behind the command. Addresses auto-increment across bytes in the same frame.

Parameters:
- ADDR_WIDTH, 7, register address width; command byte carries {RW, addr[6:0]}, so must be ≤7.
- IDLE_BYTE, 8'hA5, byte loaded into the slave TX register outside frames; master sees it during the command byte.
- AUTO_INC, 1, 1 = increment address after each data byte, 0 = hold address.

Ports:
- i_Clk  in  1  system clock, ≥4x SPI clock.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_RX_DV  in  1  one-cycle pulse, received byte valid.
- i_RX_Byte  in  8  received byte.
- o_TX_DV  out  1  one-cycle pulse, loads o_TX_Byte into slave.
- o_TX_Byte  out  8  byte to send next on MISO.
- i_SPI_CS_n  in  1  raw chip select (asynchronous; synchronised internally).
- o_Bus_Addr  out  ADDR_WIDTH  register address.
- o_Bus_Wr_En  out  1  one-cycle write strobe.
- o_Bus_Wr_Data  out  8  write data, valid with o_Bus_Wr_En.
- o_Bus_Rd_En  out  1  one-cycle read strobe.
- i_Bus_Rd_Data  in  8  read data, valid exactly 1 cycle after o_Bus_Rd_En.
- o_Frame_Active  out  1  high while synchronised CS is low.

Behaviour:
- Reset: all outputs 0, state IDLE, o_Bus_Addr 0, internal reload_pending=1.
- First cycle after reset release: o_TX_DV=1, o_TX_Byte=IDLE_BYTE.
- CS sync:
  - 2-flop synchroniser on i_SPI_CS_n, with cs_s preset to 1 on reset.
  - o_Frame_Active = ~cs_s.
  - Rising edge of cs_s (frame end): state→IDLE; next cycle pulse o_TX_DV with IDLE_BYTE.
- States: IDLE, WRITE, RD_ISSUE, RD_LOAD, READ.
- IDLE + i_RX_DV:
  - Latch addr = i_RX_Byte[ADDR_WIDTH-1:0]; bits above ADDR_WIDTH-1 other than bit 7 are ignored.
  - Bit7=0 → WRITE.
  - Bit7=1 → RD_ISSUE.
- WRITE + i_RX_DV:
  - Same cycle: o_Bus_Wr_En=1, o_Bus_Wr_Data=i_RX_Byte, o_Bus_Addr=addr.
  - addr += AUTO_INC next cycle.
  - Remain WRITE.
- RD_ISSUE:
  - o_Bus_Rd_En=1 at addr → RD_LOAD.
- RD_LOAD:
  - o_TX_DV=1, o_TX_Byte=i_Bus_Rd_Data.
  - addr += AUTO_INC → READ.
- READ + i_RX_DV (dummy byte from master, contents ignored): → RD_ISSUE, which prefetches the next byte.
- Latency:
  - Command DV to TX load: 2 cycles.
  - Data DV to bus write: 0 cycles (combinational strobe, registered address).
- Address arithmetic: modulo 2^ADDR_WIDTH; 0x7F+1 wraps to 0x00.
- i_RX_DV with cs_s=1: process normally. The final byte's DV may arrive after the raw CS rise because of sync latency; a write on that DV is performed.
- i_RX_DV and cs_s rising edge in the same cycle:
  - The byte is processed (write performed, or read issued).
  - State then goes to IDLE; frame-end IDLE_BYTE reload wins over any pending RD_LOAD.
  - The RD_LOAD TX load is suppressed.
- Frame end during RD_ISSUE/RD_LOAD: abort; no o_TX_DV with read data; IDLE_BYTE reload follows.
- Partial byte at frame end: no i_RX_DV arrives, so no action.
- Only one of o_Bus_Wr_En / o_Bus_Rd_En is ever high in a cycle.
- o_TX_DV at most one pulse per cycle.
- Reset mid-frame: immediate return to reset values; the reset-release reload rule applies.
- Each frame's first byte is always a command.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE/WRITE/RD_ISSUE/RD_LOAD/READ).
  - constants CMD_RW_BIT=7, DEFAULT_IDLE_BYTE=8'hA5.
- One natural sub-module: sync_2ff (generic 2-flop synchroniser with reset value parameter), reused for cs sync.

Test Plan:
- Reset release with CS high → o_TX_DV pulse in first cycle with o_TX_Byte=0xA5; all bus strobes 0.
- Frame: bytes 0x05, 0x11, 0x22, CS high → writes (addr 0x05, 0x11) and (0x06, 0x22); then IDLE_BYTE reload.
- Frame: 0x83, dummy, dummy with bus model returning addr+0x40 → Rd_En at 0x03, TX loads 0x43 two cycles after first DV; after dummy1, Rd_En at 0x04, TX 0x44.
- Write burst starting 0x7F with 3 data bytes → addresses 0x7F, 0x00, 0x01 (wrap).
- Read command DV coincident with cs_s rising → Rd_En issued, no read-data o_TX_DV, IDLE_BYTE reload next cycle, state IDLE.
- Assert i_Rst_L low mid-write burst → outputs 0 asynchronously; next frame's first byte decoded as command.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register bridge:
//   state_t           - byte-protocol engine states
//   CMD_RW_BIT        - bit of the command byte selecting read (1) / write (0)
//   DEFAULT_IDLE_BYTE - byte presented on MISO outside frames / during command
//   is_read_cmd()     - decodes the RW bit of a command byte
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_LOAD  = 3'd3,
    READ     = 3'd4
  } state_t;

  localparam int         CMD_RW_BIT        = 7;
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hA5;

  function automatic logic is_read_cmd(input logic [7:0] cmd);
    return cmd[CMD_RW_BIT];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   i_Clk   - destination clock
//   i_Rst_L - asynchronous active-low reset; both flops load RESET_VAL
//   i_D     - asynchronous input
//   o_Q     - synchronised output (two i_Clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= i_D;
      sync_r <= meta_r;
    end
  end

  assign o_Q = sync_r;

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Byte-level protocol engine sitting behind an SPI slave. Each chip-select
// frame is a command byte {RW, addr} followed by data bytes. Writes are
// strobed onto the register bus in the same cycle their byte arrives; reads
// are prefetched so the data is loaded into the slave TX register one byte
// ahead of the master clocking it out. Addresses auto-increment within a frame.
// Ports:
//   i_Clk, i_Rst_L      - system clock (>= 4x SPI clock), async active-low reset
//   i_RX_DV, i_RX_Byte  - received byte strobe and value from the SPI slave
//   o_TX_DV, o_TX_Byte  - load strobe and value for the slave TX register
//   i_SPI_CS_n          - raw chip select, synchronised internally
//   o_Bus_Addr          - register bus address
//   o_Bus_Wr_En/Wr_Data - write strobe and data
//   o_Bus_Rd_En         - read strobe; i_Bus_Rd_Data is valid one cycle later
//   o_Frame_Active      - high while the synchronised chip select is low
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 7,            // command byte carries 7 address bits
  parameter logic [7:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_SPI_CS_n,
  output logic [ADDR_WIDTH-1:0] o_Bus_Addr,
  output logic                  o_Bus_Wr_En,
  output logic [7:0]            o_Bus_Wr_Data,
  output logic                  o_Bus_Rd_En,
  input  logic [7:0]            i_Bus_Rd_Data,
  output logic                  o_Frame_Active
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = {{(ADDR_WIDTH-1){1'b0}}, AUTO_INC};

  logic                  cs_s;
  logic                  cs_d_r;
  logic                  cs_rise_s;
  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic                  abort_r;
  logic                  abort_nxt_s;
  logic                  reload_pending_r;
  logic                  reload_dv_r;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  rd_tx_s;

  // Chip select resets to "deasserted" so reset never looks like a frame start.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_SPI_CS_n),
    .o_Q     (cs_s)
  );

  assign cs_rise_s      = cs_s & ~cs_d_r;
  assign o_Frame_Active = ~cs_s;

  // Frame-end edge detector and IDLE_BYTE reload scheduling. The pending flag
  // survives reset as 1 so the very first post-reset cycle reloads the slave.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_d_r           <= 1'b1;
      reload_pending_r <= 1'b1;
      reload_dv_r      <= 1'b0;
    end else begin
      cs_d_r           <= cs_s;
      reload_pending_r <= 1'b0;
      reload_dv_r      <= reload_pending_r | cs_rise_s;
    end
  end

  // State, address and abort registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= IDLE;
      addr_r  <= '0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      abort_r <= abort_nxt_s;
    end
  end

  // Next-state and bus strobe decode. A byte arriving together with the frame
  // end is still honoured; for a read this means one final RD_ISSUE marked by
  // abort_r, after which the engine returns to IDLE without loading TX data.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    abort_nxt_s = 1'b0;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    rd_tx_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_RX_DV) begin
          addr_nxt_s = i_RX_Byte[ADDR_WIDTH-1:0];
          if (is_read_cmd(i_RX_Byte)) begin
            state_nxt_s = RD_ISSUE;
            abort_nxt_s = cs_rise_s;
          end else if (cs_rise_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WRITE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (i_RX_DV) begin
          wr_en_s    = 1'b1;
          addr_nxt_s = addr_r + ADDR_INC;
        end else begin
          addr_nxt_s = addr_r;
        end
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      RD_ISSUE: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          rd_en_s = 1'b1;
          if (abort_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RD_LOAD;
          end
        end
      end
      RD_LOAD: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          rd_tx_s     = 1'b1;
          addr_nxt_s  = addr_r + ADDR_INC;
          state_nxt_s = READ;
        end
      end
      READ: begin
        // Dummy byte from the master triggers the next prefetch.
        if (i_RX_DV) begin
          state_nxt_s = RD_ISSUE;
          abort_nxt_s = cs_rise_s;
        end else if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // TX load mux: the frame-end reload always takes priority over read data.
  always_comb begin
    o_TX_DV   = 1'b0;
    o_TX_Byte = 8'h00;
    if (reload_dv_r) begin
      o_TX_DV   = 1'b1;
      o_TX_Byte = IDLE_BYTE;
    end else if (rd_tx_s) begin
      o_TX_DV   = 1'b1;
      o_TX_Byte = i_Bus_Rd_Data;
    end else begin
      o_TX_DV   = 1'b0;
      o_TX_Byte = 8'h00;
    end
  end

  assign o_Bus_Addr    = addr_r;
  assign o_Bus_Wr_En   = wr_en_s;
  assign o_Bus_Wr_Data = wr_en_s ? i_RX_Byte : 8'h00;
  assign o_Bus_Rd_En   = rd_en_s;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Directed self-checking bench for spi_reg_bridge. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. A small bus
// model returns {0,addr}+0x40 one cycle after each read strobe.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

  logic       clk;
  logic       rst_l;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       cs_n;
  logic [6:0] bus_addr;
  logic       bus_wr_en;
  logic [7:0] bus_wr_data;
  logic       bus_rd_en;
  logic [7:0] bus_rd_data;
  logic       frame_active;

  int tests;
  int failed;

  spi_reg_bridge u_dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_l),
    .i_RX_DV        (rx_dv),
    .i_RX_Byte      (rx_byte),
    .o_TX_DV        (tx_dv),
    .o_TX_Byte      (tx_byte),
    .i_SPI_CS_n     (cs_n),
    .o_Bus_Addr     (bus_addr),
    .o_Bus_Wr_En    (bus_wr_en),
    .o_Bus_Wr_Data  (bus_wr_data),
    .o_Bus_Rd_En    (bus_rd_en),
    .i_Bus_Rd_Data  (bus_rd_data),
    .o_Frame_Active (frame_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register bus read model: data valid exactly one cycle after the strobe.
  always @(posedge clk) begin
    bus_rd_data <= bus_rd_en ? ({1'b0, bus_addr} + 8'h40) : 8'h00;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    #12;
    tests++; if (tx_dv !== 1'b0) begin failed++; $display("FAIL rst_tx_dv: got %0b want 0", tx_dv); end
    tests++; if (tx_byte !== 8'h00) begin failed++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
    tests++; if (bus_wr_en !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL rst_strobes: got wr=%0b rd=%0b want 0/0", bus_wr_en, bus_rd_en); end
    tests++; if (bus_addr !== 7'h00) begin failed++; $display("FAIL rst_addr: got %h want 00", bus_addr); end
    tests++; if (frame_active !== 1'b0) begin failed++; $display("FAIL rst_frame_active: got %0b want 0", frame_active); end
    @(negedge clk);
    rst_l = 1'b1;
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failed++; $display("FAIL rst_reload: got dv=%0b byte=%h want 1/a5", tx_dv, tx_byte); end
    tests++; if (bus_wr_en !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL rst_reload_strobes: got wr=%0b rd=%0b want 0/0", bus_wr_en, bus_rd_en); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0) begin failed++; $display("FAIL rst_reload_once: got %0b want 0", tx_dv); end
  endtask

  task automatic test_write_frame();
    cs_n = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    tests++; if (frame_active !== 1'b1) begin failed++; $display("FAIL wr_frame_active: got %0b want 1", frame_active); end
    step();
    rx_dv = 1'b1; rx_byte = 8'h05;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL wr_cmd_no_strobe: got wr=%0b rd=%0b want 0/0", bus_wr_en, bus_rd_en); end
    step(); rx_dv = 1'b0; idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h11;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h05 || bus_wr_data !== 8'h11) begin failed++; $display("FAIL wr_byte1: got en=%0b addr=%h data=%h want 1/05/11", bus_wr_en, bus_addr, bus_wr_data); end
    tests++; if (bus_rd_en !== 1'b0) begin failed++; $display("FAIL wr_byte1_rd: got %0b want 0", bus_rd_en); end
    step(); rx_dv = 1'b0; idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h22;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h06 || bus_wr_data !== 8'h22) begin failed++; $display("FAIL wr_byte2: got en=%0b addr=%h data=%h want 1/06/22", bus_wr_en, bus_addr, bus_wr_data); end
    step(); rx_dv = 1'b0;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b0) begin failed++; $display("FAIL wr_strobe_one_cycle: got %0b want 0", bus_wr_en); end
    cs_n = 1'b1;
    idle_cycles(2);
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0 || frame_active !== 1'b0) begin failed++; $display("FAIL wr_end_edge: got dv=%0b fa=%0b want 0/0", tx_dv, frame_active); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failed++; $display("FAIL wr_end_reload: got dv=%0b byte=%h want 1/a5", tx_dv, tx_byte); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0) begin failed++; $display("FAIL wr_end_reload_once: got %0b want 0", tx_dv); end
    idle_cycles(2);
  endtask

  task automatic test_read_frame();
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
    cs_n = 1'b0;
    idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h83;
    @(negedge clk);
    tests++; if (bus_rd_en !== 1'b0 || tx_dv !== 1'b0) begin failed++; $display("FAIL rd_cmd_cycle: got rd=%0b dv=%0b want 0/0", bus_rd_en, tx_dv); end
    step(); rx_dv = 1'b0;
    @(negedge clk);
    tests++; if (bus_rd_en !== 1'b1 || bus_addr !== 7'h03 || bus_wr_en !== 1'b0) begin failed++; $display("FAIL rd_issue0: got rd=%0b addr=%h wr=%0b want 1/03/0", bus_rd_en, bus_addr, bus_wr_en); end
    tests++; if (tx_dv !== 1'b0) begin failed++; $display("FAIL rd_issue0_tx: got %0b want 0", tx_dv); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'h43 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL rd_load0: got dv=%0b byte=%h rd=%0b want 1/43/0", tx_dv, tx_byte, bus_rd_en); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0) begin failed++; $display("FAIL rd_load0_once: got %0b want 0", tx_dv); end
    idle_cycles(3);
    for (int k = 0; k < 2; k++) begin
      exp_addr = 7'h04 + 7'(k);
      exp_data = 8'h44 + 8'(k);
      rx_dv = 1'b1; rx_byte = 8'hFF;
      @(negedge clk);
      tests++; if (bus_rd_en !== 1'b0 || bus_wr_en !== 1'b0) begin failed++; $display("FAIL rd_dummy%0d_cycle: got rd=%0b wr=%0b want 0/0", k, bus_rd_en, bus_wr_en); end
      step(); rx_dv = 1'b0;
      @(negedge clk);
      tests++; if (bus_rd_en !== 1'b1 || bus_addr !== exp_addr) begin failed++; $display("FAIL rd_issue%0d: got rd=%0b addr=%h want 1/%h", k + 1, bus_rd_en, bus_addr, exp_addr); end
      step();
      @(negedge clk);
      tests++; if (tx_dv !== 1'b1 || tx_byte !== exp_data) begin failed++; $display("FAIL rd_load%0d: got dv=%0b byte=%h want 1/%h", k + 1, tx_dv, tx_byte, exp_data); end
      idle_cycles(4);
    end
    cs_n = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failed++; $display("FAIL rd_end_reload: got dv=%0b byte=%h want 1/a5", tx_dv, tx_byte); end
    idle_cycles(2);
  endtask

  task automatic test_write_wrap();
    logic [6:0] exp_addr [3];
    exp_addr = '{7'h7F, 7'h00, 7'h01};
    cs_n = 1'b0;
    idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h7F;
    step(); rx_dv = 1'b0; idle_cycles(3);
    for (int k = 0; k < 3; k++) begin
      rx_dv = 1'b1; rx_byte = 8'hA0 + 8'(k);
      @(negedge clk);
      tests++; if (bus_wr_en !== 1'b1 || bus_addr !== exp_addr[k] || bus_wr_data !== (8'hA0 + 8'(k))) begin failed++; $display("FAIL wrap_byte%0d: got en=%0b addr=%h data=%h want 1/%h/%h", k, bus_wr_en, bus_addr, bus_wr_data, exp_addr[k], 8'hA0 + 8'(k)); end
      step(); rx_dv = 1'b0; idle_cycles(3);
    end
    cs_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_read_cs_coincide();
    cs_n = 1'b0;
    idle_cycles(3);
    cs_n = 1'b1;
    idle_cycles(2);
    // This cycle carries the synchronised chip-select rising edge.
    rx_dv = 1'b1; rx_byte = 8'h8A;
    @(negedge clk);
    tests++; if (frame_active !== 1'b0 || bus_rd_en !== 1'b0 || tx_dv !== 1'b0) begin failed++; $display("FAIL co_edge_cycle: got fa=%0b rd=%0b dv=%0b want 0/0/0", frame_active, bus_rd_en, tx_dv); end
    step(); rx_dv = 1'b0;
    @(negedge clk);
    tests++; if (bus_rd_en !== 1'b1 || bus_addr !== 7'h0A) begin failed++; $display("FAIL co_rd_issued: got rd=%0b addr=%h want 1/0a", bus_rd_en, bus_addr); end
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failed++; $display("FAIL co_reload: got dv=%0b byte=%h want 1/a5", tx_dv, tx_byte); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL co_no_rd_load: got dv=%0b byte=%h rd=%0b want 0/00/0", tx_dv, tx_byte, bus_rd_en); end
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL co_quiet: got dv=%0b rd=%0b want 0/0", tx_dv, bus_rd_en); end
    cs_n = 1'b0;
    idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h10;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b0 || bus_rd_en !== 1'b0) begin failed++; $display("FAIL co_next_cmd: got wr=%0b rd=%0b want 0/0", bus_wr_en, bus_rd_en); end
    step(); rx_dv = 1'b0; idle_cycles(2);
    rx_dv = 1'b1; rx_byte = 8'h55;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h10 || bus_wr_data !== 8'h55) begin failed++; $display("FAIL co_next_write: got en=%0b addr=%h data=%h want 1/10/55", bus_wr_en, bus_addr, bus_wr_data); end
    step(); rx_dv = 1'b0;
    cs_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_reset_mid_burst();
    cs_n = 1'b0;
    idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h20;
    step(); rx_dv = 1'b0; idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h01;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h20) begin failed++; $display("FAIL mid_write0: got en=%0b addr=%h want 1/20", bus_wr_en, bus_addr); end
    step(); rx_dv = 1'b0; idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h02;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h21) begin failed++; $display("FAIL mid_write1: got en=%0b addr=%h want 1/21", bus_wr_en, bus_addr); end
    #1 rst_l = 1'b0;
    #1;
    tests++; if (bus_wr_en !== 1'b0 || bus_addr !== 7'h00 || bus_wr_data !== 8'h00) begin failed++; $display("FAIL mid_async_bus: got en=%0b addr=%h data=%h want 0/00/00", bus_wr_en, bus_addr, bus_wr_data); end
    tests++; if (tx_dv !== 1'b0 || frame_active !== 1'b0) begin failed++; $display("FAIL mid_async_misc: got dv=%0b fa=%0b want 0/0", tx_dv, frame_active); end
    rx_dv = 1'b0;
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    step();
    @(negedge clk);
    tests++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failed++; $display("FAIL mid_reload: got dv=%0b byte=%h want 1/a5", tx_dv, tx_byte); end
    idle_cycles(2);
    cs_n = 1'b0;
    idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h30;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b0) begin failed++; $display("FAIL mid_next_is_cmd: got wr=%0b want 0", bus_wr_en); end
    step(); rx_dv = 1'b0; idle_cycles(3);
    rx_dv = 1'b1; rx_byte = 8'h77;
    @(negedge clk);
    tests++; if (bus_wr_en !== 1'b1 || bus_addr !== 7'h30 || bus_wr_data !== 8'h77) begin failed++; $display("FAIL mid_next_write: got en=%0b addr=%h data=%h want 1/30/77", bus_wr_en, bus_addr, bus_wr_data); end
    step(); rx_dv = 1'b0;
    cs_n = 1'b1;
    idle_cycles(4);
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst_l   = 1'b0;
    cs_n    = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    test_reset();
    test_write_frame();
    test_read_frame();
    test_write_wrap();
    test_read_cs_coincide();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
